// File: rtl/serial_frame_pkg.sv
// Shared definitions for the parity frame serializer: FSM state encoding and default payload width.
package serial_frame_pkg;
  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;
endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out register, LSB first. sout is the flop at bit 0, so the stream is registered.
module piso_shift_reg #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic             sout
);
  logic [WIDTH-1:0] sr;

  // Zeros shift in from the top, so the register drains to 0 once the frame is out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         sr <= '0;
    else if (load)     sr <= din;
    else if (shift_en) sr <= {1'b0, sr[WIDTH-1:1]};
  end

  assign sout = sr[0];
endmodule

// File: rtl/parity_frame_serializer.sv
// Serializes WIDTH-bit words LSB first, appending one parity bit per frame; frames may run back to back.
module parity_frame_serializer
  import serial_frame_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter bit ODD   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             x,
  output logic             x_valid,
  output logic             frame_end
);
  localparam int IW = $clog2(WIDTH);

  state_t        state;
  logic [IW-1:0] idx;
  logic          xfer, last, pbit;

  assign data_ready = (state != SHIFT);
  assign xfer       = data_valid & data_ready;
  assign last       = (idx == IW'(WIDTH - 1));
  assign pbit       = (^data_in) ^ ODD;

  // The parity bit rides above the payload so it falls out of bit 0 right after the MSB.
  piso_shift_reg #(.WIDTH(WIDTH + 1)) u_piso (
    .clk      (clk),
    .reset    (reset),
    .load     (xfer),
    .shift_en (state != IDLE),
    .din      ({pbit, data_in}),
    .sout     (x)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      x_valid   <= 1'b0;
      frame_end <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            state   <= SHIFT;
            idx     <= '0;
            x_valid <= 1'b1;
          end
        end
        SHIFT: begin
          if (last) begin
            state     <= PARITY;
            idx       <= '0;
            frame_end <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        PARITY: begin
          frame_end <= 1'b0;
          idx       <= '0;
          if (xfer) begin
            state <= SHIFT;
          end else begin
            state   <= IDLE;
            x_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          idx       <= '0;
          x_valid   <= 1'b0;
          frame_end <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_parity_frame_serializer.sv
// Bench for parity_frame_serializer: even and odd instances share stimulus and are checked against a frame-queue model.
module tb_parity_frame_serializer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         data_valid = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         r0, x0, xv0, fe0;
  logic         r1, x1, xv1, fe1;

  parity_frame_serializer #(.WIDTH(W), .ODD(1'b0)) dut0 (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(r0), .x(x0), .x_valid(xv0), .frame_end(fe0));

  parity_frame_serializer #(.WIDTH(W), .ODD(1'b1)) dut1 (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(r1), .x(x1), .x_valid(xv1), .frame_end(fe1));

  always #5 clk = ~clk;

  // One entry per expected x_valid cycle: bit for the even instance, bit for the odd one, parity flag.
  typedef struct packed {logic b0; logic b1; logic fe;} ent_t;
  ent_t q[$];

  int   n_cmp = 0, n_bad = 0, n_acc = 0;
  int   run = 0, maxrun = 0;
  logic acc0 = 1'b0, acc1 = 1'b0;
  logic capq[$];
  logic pq0[$];
  logic pq1[$];

  function automatic logic [17:0] capvec();
    logic [17:0] v = '0;
    for (int i = 0; i < 18 && i < capq.size(); i++) v[i] = capq[i];
    return v;
  endfunction

  // Called at a falling edge: check outputs against the model, drive inputs, advance one clock.
  task automatic step(input logic v, input logic [W-1:0] d);
    logic exp_v, exp_r, accept;
    exp_v = (q.size() != 0);
    exp_r = (q.size() <= 1);
    n_cmp++;
    if (xv0 !== exp_v || xv1 !== exp_v) begin
      n_bad++;
      $display("FAIL x_valid @%0t: got %b/%b want %b", $time, xv0, xv1, exp_v);
    end
    n_cmp++;
    if (exp_v) begin
      if (x0 !== q[0].b0 || x1 !== q[0].b1 || fe0 !== q[0].fe || fe1 !== q[0].fe) begin
        n_bad++;
        $display("FAIL stream @%0t: got x=%b/%b fe=%b/%b want x=%b/%b fe=%b",
                 $time, x0, x1, fe0, fe1, q[0].b0, q[0].b1, q[0].fe);
      end
    end else if (x0 !== 1'b0 || x1 !== 1'b0 || fe0 !== 1'b0 || fe1 !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_out @%0t: got x=%b/%b fe=%b/%b want 0", $time, x0, x1, fe0, fe1);
    end
    n_cmp++;
    if (r0 !== exp_r || r1 !== exp_r) begin
      n_bad++;
      $display("FAIL data_ready @%0t: got %b/%b want %b", $time, r0, r1, exp_r);
    end
    if (xv0 === 1'b1) begin
      acc0 = acc0 ^ x0;
      acc1 = acc1 ^ x1;
      capq.push_back(x0);
      run++;
      if (run > maxrun) maxrun = run;
      if (fe0 === 1'b1) pq0.push_back(x0);
      if (fe1 === 1'b1) pq1.push_back(x1);
      if (fe0 === 1'b1) begin
        n_cmp++;
        if (acc0 !== 1'b0 || acc1 !== 1'b1) begin
          n_bad++;
          $display("FAIL frame_parity @%0t: got even=%b odd=%b want 0/1", $time, acc0, acc1);
        end
        acc0 = 1'b0;
        acc1 = 1'b0;
      end
    end else begin
      run = 0;
    end
    data_valid = v;
    data_in    = d;
    accept     = v && (q.size() <= 1);
    @(posedge clk);
    if (q.size() != 0) void'(q.pop_front());
    if (accept) begin
      for (int i = 0; i < W; i++) q.push_back('{b0: d[i], b1: d[i], fe: 1'b0});
      q.push_back('{b0: ^d, b1: ~(^d), fe: 1'b1});
      n_acc++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if (xv0 !== 1'b0 || xv1 !== 1'b0 || x0 !== 1'b0 || fe0 !== 1'b0 || r0 !== 1'b1 || r1 !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_state: got xv=%b x=%b fe=%b rdy=%b/%b want 0 0 0 1/1", xv0, x0, fe0, r0, r1);
    end
    reset = 1'b0;
  endtask

  task automatic test_a5();
    capq.delete(); pq0.delete();
    step(1'b1, 8'hA5);
    repeat (10) step(1'b0, 8'h00);
    n_cmp++;
    if (capq.size() != 9 || capvec() !== {9'h000, 9'h0A5}) begin
      n_bad++;
      $display("FAIL a5_stream: got %0d bits %h want 9 bits %h", capq.size(), capvec(), {9'h000, 9'h0A5});
    end
    n_cmp++;
    if (pq0.size() != 1) begin
      n_bad++;
      $display("FAIL a5_frame_end: got %0d frame_end cycles want 1", pq0.size());
    end
  endtask

  task automatic test_parity_07();
    pq0.delete(); pq1.delete();
    step(1'b1, 8'h07);
    repeat (10) step(1'b0, 8'h00);
    n_cmp++;
    if (pq0.size() != 1 || pq1.size() != 1 || pq0[0] !== 1'b1 || pq1[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL parity_07: got even=%b odd=%b want 1/0",
               pq0.size() ? pq0[0] : 1'bx, pq1.size() ? pq1[0] : 1'bx);
    end
  endtask

  task automatic test_back_to_back();
    capq.delete(); pq0.delete(); maxrun = 0;
    step(1'b1, 8'h01);
    repeat (9) step(1'b1, 8'hFF);
    repeat (12) step(1'b0, 8'h00);
    n_cmp++;
    if (maxrun != 18) begin
      n_bad++;
      $display("FAIL b2b_run: got %0d contiguous x_valid want 18", maxrun);
    end
    n_cmp++;
    if (capq.size() != 18 || capvec() !== {9'h0FF, 9'h101}) begin
      n_bad++;
      $display("FAIL b2b_stream: got %h want %h", capvec(), {9'h0FF, 9'h101});
    end
    n_cmp++;
    if (pq0.size() != 2 || pq0[0] !== 1'b1 || pq0[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_parity: got %0d parity bits want 1,0", pq0.size());
    end
  endtask

  task automatic test_ignore_during_shift();
    capq.delete();
    step(1'b1, 8'h81);
    repeat (9) step(1'b1, 8'h3C);
    repeat (12) step(1'b0, 8'h00);
    n_cmp++;
    if (capq.size() != 18 || capvec() !== {9'h03C, 9'h081}) begin
      n_bad++;
      $display("FAIL hold_shift: got %0d bits %h want %h", capq.size(), capvec(), {9'h03C, 9'h081});
    end
  endtask

  task automatic test_reset_midframe();
    step(1'b1, 8'hF0);
    repeat (3) step(1'b0, 8'h00);
    data_valid = 1'b1;
    data_in    = 8'h55;
    reset      = 1'b1;
    #1;
    n_cmp++;
    if (xv0 !== 1'b0 || xv1 !== 1'b0 || x0 !== 1'b0 || fe0 !== 1'b0 || r0 !== 1'b1 || r1 !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid: got xv=%b/%b x=%b fe=%b rdy=%b/%b want 0/0 0 0 1/1", xv0, xv1, x0, fe0, r0, r1);
    end
    q.delete(); acc0 = 1'b0; acc1 = 1'b0; run = 0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (xv0 !== 1'b0 || xv1 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_xfer: got x_valid=%b/%b want 0", xv0, xv1);
    end
    reset = 1'b0;
    data_valid = 1'b0;
    capq.delete();
    step(1'b1, 8'h0F);
    repeat (10) step(1'b0, 8'h00);
    n_cmp++;
    if (capq.size() != 9 || capvec() !== {9'h000, 9'h00F}) begin
      n_bad++;
      $display("FAIL after_reset: got %0d bits %h want %h", capq.size(), capvec(), {9'h000, 9'h00F});
    end
  endtask

  task automatic test_random();
    int guard = 0;
    n_acc = 0;
    while (n_acc < 1000 && guard < 20000) begin
      step($urandom_range(0, 3) != 0, 8'($urandom));
      guard++;
    end
    repeat (12) step(1'b0, 8'h00);
    n_cmp++;
    if (n_acc != 1000) begin
      n_bad++;
      $display("FAIL random_words: got %0d accepted want 1000", n_acc);
    end
  endtask

  initial begin
    test_reset();
    test_a5();
    test_parity_07();
    test_back_to_back();
    test_ignore_during_shift();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/parity_frame_serializer.md
PARITY_FRAME_SERIALIZER -- requirements
Module: parity_frame_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the number of payload bits per frame (legal range 2..32).
REQ-002 SHALL have parameter ODD, default 0, meaning the parity sense: 0 = even, 1 = odd.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port data_in  input  WIDTH  parallel payload word.
REQ-006 SHALL have port data_valid  input  1  data_in is offered this cycle.
REQ-007 SHALL have port data_ready  output  1  block accepts data_in this cycle.
REQ-008 SHALL have port x  output  1  serial bit stream, registered.
REQ-009 SHALL have port x_valid  output  1  x carries a frame bit this cycle, registered.
REQ-010 SHALL have port frame_end  output  1  x carries the parity bit (last bit of frame), registered.

Function
REQ-011 SHALL implement an FSM with states IDLE, SHIFT and PARITY.
REQ-012 SHALL complete a transfer on any rising edge where data_valid=1 and data_ready=1; no transfer otherwise.
REQ-013 SHALL drive data_ready=1 in IDLE and PARITY only, and 0 in SHIFT; data_ready is decoded from state alone, with no combinational path from data_valid.
REQ-014 On a transfer, SHALL latch data_in, compute pbit = XOR(data_in) XOR ODD, and enter SHIFT with bit index 0.
REQ-015 In SHIFT, SHALL drive x = latched bit[index], LSB first, with x_valid=1 and frame_end=0; index increments each cycle; after index WIDTH-1 it SHALL enter PARITY.
REQ-016 In PARITY, SHALL drive x = pbit, x_valid=1 and frame_end=1 for exactly one cycle.
REQ-017 From PARITY, SHALL enter SHIFT (new word) if a transfer occurs that cycle, otherwise IDLE; back-to-back frames therefore have no gap cycle.
REQ-018 In IDLE, SHALL drive x=0, x_valid=0 and frame_end=0.
REQ-019 Latency SHALL be one cycle from the transfer edge to the first payload bit on x; one frame SHALL occupy exactly WIDTH+1 consecutive x_valid cycles.
REQ-020 In SHIFT, SHALL ignore data_valid and SHALL NOT alter the latched word.
REQ-021 Bit index width SHALL be $clog2(WIDTH); the index SHALL wrap to 0 on the SHIFT-to-PARITY transition.
REQ-022 Over each frame, the total count of 1s on x (payload plus parity) SHALL be even when ODD=0 and odd when ODD=1, so a downstream running-parity checker reads 0 (ODD=0) after frame_end.

Reset
REQ-023 Assertion of reset SHALL immediately force IDLE, x=0, x_valid=0, frame_end=0, index=0 and shift register=0; data_ready then reads 1.
REQ-024 Reset asserted mid-frame SHALL abandon the frame with no further bits emitted; any transfer coincident with reset SHALL be discarded.
REQ-025 After reset deasserts, the first rising edge SHALL be able to complete a transfer.

Structure
REQ-026 State encoding constants (IDLE, SHIFT, PARITY) and the default WIDTH SHALL reside in shared package serial_frame_pkg.
REQ-027 Latched word and LSB-first shifting SHALL be a sub-module piso_shift_reg (load, shift_en, serial out); the FSM, counter and parity logic SHALL stay in the top level.

Verification
REQ-028 ODD=0, transfer 0xA5 -> x = 1,0,1,0,0,1,0,1 then parity 0; frame_end=1 on the 9th cycle only.
REQ-029 ODD=0, transfer 0x07 -> parity bit 1; ODD=1, transfer 0x07 -> parity bit 0.
REQ-030 0x01 and then 0xFF offered back-to-back with data_valid held high -> 18 contiguous x_valid cycles; 0xFF transfers on the PARITY cycle of 0x01; parity bits 1 and 0.
REQ-031 data_valid=1 with 0x3C during SHIFT of 0x81 -> 0x3C not accepted until PARITY; 0x81 bits unaffected.
REQ-032 reset pulsed on the 4th bit of 0xF0 -> x_valid=0 the same cycle, IDLE state, data_ready=1; next transfer 0x0F serializes cleanly.
REQ-033 Bench SHALL feed x/x_valid into a reference parity model and check that every frame_end cycle yields even total parity (ODD=0) across 1000 random words.
